// File: rtl/ir_pkg.sv
// Shared types and default sizes for the instruction register block and
// the decoder that consumes its immediates.
package ir_pkg;

  localparam int IR_WIDTH   = 16;
  localparam int IR_DEPTH   = 2;
  localparam int IR_SHORT_W = 5;
  localparam int IR_LONG_W  = 8;

  // Encoding of the immediate format select; 00/01 keep their historic
  // long/short meaning.
  typedef enum logic [1:0] {
    IMM_LONG   = 2'd0,
    IMM_SHORT  = 2'd1,
    IMM_LONG_U = 2'd2,
    IMM_UPPER  = 2'd3
  } imm_sel_t;

endpackage

// File: rtl/ir_imm_extract.sv
// Combinational immediate extractor. Pulls the short or long immediate field
// out of an instruction word and sign-extends, zero-extends or left-justifies
// it to the full word width.
module ir_imm_extract
  import ir_pkg::*;
#(
  parameter int WIDTH   = IR_WIDTH,
  parameter int SHORT_W = IR_SHORT_W,
  parameter int LONG_W  = IR_LONG_W
) (
  input  logic [WIDTH-1:0] ir,
  input  imm_sel_t         sel,
  output logic [WIDTH-1:0] imm
);

  // Select and extend the requested immediate field.
  always_comb begin
    imm = '0;
    case (sel)
      IMM_LONG:   imm = {{(WIDTH-LONG_W){ir[LONG_W-1]}}, ir[LONG_W-1:0]};
      IMM_SHORT:  imm = {{(WIDTH-SHORT_W){ir[SHORT_W-1]}}, ir[SHORT_W-1:0]};
      IMM_LONG_U: imm = {{(WIDTH-LONG_W){1'b0}}, ir[LONG_W-1:0]};
      IMM_UPPER:  imm = {ir[LONG_W-1:0], {(WIDTH-LONG_W){1'b0}}};
      default:    imm = '0;
    endcase
  end

endmodule

// File: rtl/ir_prefetch.sv
// Instruction register with a small prefetch queue behind it.
//
// Flow control: a push (IrWe) is taken on a rising edge only when Full was
// low before that edge; Full is registered, so a push offered while Full=1
// is dropped and the producer must retry. Advance is the decoder's
// "consumed" strobe and only acts while IrValid=1. Push and Advance may
// coincide and both take effect. Test (scan) and Flush override both.
module ir_prefetch
  import ir_pkg::*;
#(
  parameter int WIDTH   = IR_WIDTH,
  parameter int DEPTH   = IR_DEPTH,
  parameter int SHORT_W = IR_SHORT_W,
  parameter int LONG_W  = IR_LONG_W
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Test,
  input  logic                         SDI,
  output logic                         SDO,
  input  logic [WIDTH-1:0]             SysBus,
  input  logic                         IrWe,
  output logic                         Full,
  input  logic                         Advance,
  input  logic                         Flush,
  input  logic [1:0]                   ImmSel,
  output logic [WIDTH-1:0]             Ir,
  output logic                         IrValid,
  output logic [WIDTH-1:0]             Imm,
  output logic [$clog2(DEPTH+2)-1:0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int CW = $clog2(DEPTH+2);

  logic [WIDTH-1:0] ir_q;
  logic             ir_valid_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [OW-1:0]    occ;

  logic             push_ok;
  logic             adv;
  logic             fifo_empty;
  logic             fifo_wr;
  logic             fifo_rd;
  logic [WIDTH-1:0] ir_next;
  logic             valid_next;

  assign Full    = (occ == OW'(DEPTH));
  assign Ir      = ir_q;
  assign IrValid = ir_valid_q;
  assign SDO     = ir_q[WIDTH-1];
  assign Count   = CW'(occ) + CW'(ir_valid_q);

  // Decide where a pushed word lands and what the instruction register
  // becomes on the next edge in normal (non-scan, non-flush) operation.
  always_comb begin
    push_ok    = IrWe & ~Full;
    adv        = Advance & ir_valid_q;
    fifo_empty = (occ == '0);
    fifo_wr    = 1'b0;
    fifo_rd    = 1'b0;
    ir_next    = ir_q;
    valid_next = ir_valid_q;
    if (adv) begin
      if (!fifo_empty) begin
        ir_next = mem[rd_ptr];
        fifo_rd = 1'b1;
        fifo_wr = push_ok;
      end else if (push_ok) begin
        // Empty queue: the incoming word replaces the consumed one directly.
        ir_next    = SysBus;
        valid_next = 1'b1;
      end else begin
        // Nothing to replace it with; Ir keeps its stale value.
        valid_next = 1'b0;
      end
    end else if (push_ok) begin
      if (!ir_valid_q) begin
        ir_next    = SysBus;
        valid_next = 1'b1;
      end else begin
        fifo_wr = 1'b1;
      end
    end
  end

  // Instruction register, valid flag, queue pointers and occupancy.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
    end else if (Test) begin
      // Scan shifts the instruction register only; everything else holds.
      ir_q <= {ir_q[WIDTH-2:0], SDI};
    end else if (Flush) begin
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
    end else begin
      ir_q       <= ir_next;
      ir_valid_q <= valid_next;
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      occ <= occ + OW'(fifo_wr) - OW'(fifo_rd);
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge Clock) begin
    if (!Reset && !Test && !Flush && fifo_wr) begin
      mem[wr_ptr] <= SysBus;
    end
  end

  ir_imm_extract #(
    .WIDTH   (WIDTH),
    .SHORT_W (SHORT_W),
    .LONG_W  (LONG_W)
  ) u_imm (
    .ir  (ir_q),
    .sel (imm_sel_t'(ImmSel)),
    .imm (Imm)
  );

endmodule
